// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline-stage register with a valid/ready handshake.
// It carries regwrite/a3/src/Tnew/data fields, saturates Tnew down by one
// on capture, and presents an all-zero bubble whenever it holds no entry.
// Build option: define PIPE_STAGE_SKID_EN for a two-entry (main + skid)
// stage whose in_ready is a register. Without it the stage has a single
// entry and a combinational in_ready.
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int TNEW_W = 4,
    parameter int SRC_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_regwrite,
    input  logic [4:0]        in_a3,
    input  logic [SRC_W-1:0]  in_src,
    input  logic [TNEW_W-1:0] in_tnew,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_regwrite,
    output logic [4:0]        out_a3,
    output logic [SRC_W-1:0]  out_src,
    output logic [TNEW_W-1:0] out_tnew,
    output logic [DATA_W-1:0] out_data
);

    // Tnew counts down by one per stage and stops at zero.
    function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    logic              m_valid;
    logic              m_regwrite;
    logic [4:0]        m_a3;
    logic [SRC_W-1:0]  m_src;
    logic [TNEW_W-1:0] m_tnew;
    logic [DATA_W-1:0] m_data;

    logic accept;
    assign accept = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              s_valid;
    logic              s_regwrite;
    logic [4:0]        s_a3;
    logic [SRC_W-1:0]  s_src;
    logic [TNEW_W-1:0] s_tnew;
    logic [DATA_W-1:0] s_data;

    // in_ready comes straight from the skid flag, so out_ready never reaches it.
    assign in_ready = !s_valid;

    // Main refills from skid first (older entry); a new input goes to main
    // when main frees up, otherwise it parks in skid while main is stalled.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (!m_valid || out_ready) begin
            if (s_valid) begin
                m_valid    <= 1'b1;
                m_regwrite <= s_regwrite;
                m_a3       <= s_a3;
                m_src      <= s_src;
                m_tnew     <= s_tnew;
                m_data     <= s_data;
                s_valid    <= 1'b0;
            end else if (accept) begin
                m_valid    <= 1'b1;
                m_regwrite <= in_regwrite;
                m_a3       <= in_a3;
                m_src      <= in_src;
                m_tnew     <= tnew_dec(in_tnew);
                m_data     <= in_data;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (accept) begin
            s_valid    <= 1'b1;
            s_regwrite <= in_regwrite;
            s_a3       <= in_a3;
            s_src      <= in_src;
            s_tnew     <= tnew_dec(in_tnew);
            s_data     <= in_data;
        end
    end
`else
    // A single entry can take new data whenever it is empty or draining.
    assign in_ready = !m_valid || out_ready;

    // Capture on accept (covers pass-through), empty on a plain dequeue.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            m_valid <= 1'b0;
        end else if (accept) begin
            m_valid    <= 1'b1;
            m_regwrite <= in_regwrite;
            m_a3       <= in_a3;
            m_src      <= in_src;
            m_tnew     <= tnew_dec(in_tnew);
            m_data     <= in_data;
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end
`endif

    // Empty stage shows an all-zero bubble to the hazard logic.
    always_comb begin
        out_valid    = m_valid;
        out_regwrite = m_valid & m_regwrite;
        out_a3       = m_valid ? m_a3   : '0;
        out_src      = m_valid ? m_src  : '0;
        out_tnew     = m_valid ? m_tnew : '0;
        out_data     = m_valid ? m_data : '0;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (default parameters); follows the
// PIPE_STAGE_SKID_EN define when the design is built with it.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, in_regwrite;
    logic [4:0]  in_a3;
    logic [2:0]  in_src;
    logic [3:0]  in_tnew;
    logic [95:0] in_data;
    logic        out_valid, out_ready, out_regwrite;
    logic [4:0]  out_a3;
    logic [2:0]  out_src;
    logic [3:0]  out_tnew;
    logic [95:0] out_data;

    int unsigned passes = 0;
    int unsigned total  = 0;

    pipe_stage_reg #(.DATA_W(96), .TNEW_W(4), .SRC_W(3)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_regwrite(in_regwrite), .in_a3(in_a3), .in_src(in_src),
        .in_tnew(in_tnew), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_regwrite(out_regwrite), .out_a3(out_a3), .out_src(out_src),
        .out_tnew(out_tnew), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic offer(input logic rw, input logic [4:0] a3, input logic [2:0] src,
                         input logic [3:0] tn, input logic [95:0] d);
        in_valid = 1'b1; in_regwrite = rw; in_a3 = a3; in_src = src;
        in_tnew = tn; in_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_regwrite = 1'b0; in_a3 = '0; in_src = '0; in_tnew = '0; in_data = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_a3", out_a3, 0);
        chk("rst_data", out_data, 0);
        chk("rst_tnew", out_tnew, 0);

        // Basic capture: Tnew 3 -> 2
        offer(1'b1, 5'd8, 3'd2, 4'd3, 96'h1234);
        step();
        chk("cap_valid", out_valid, 1);
        chk("cap_tnew", out_tnew, 2);
        chk("cap_a3", out_a3, 8);
        chk("cap_data", out_data, 128'h1234);
        chk("cap_rw", out_regwrite, 1);
        chk("cap_src", out_src, 2);

        // Saturation at zero, back-to-back pass-through
        offer(1'b1, 5'd1, 3'd0, 4'd0, 96'hA);
        step();
        chk("t0_tnew", out_tnew, 0);
        chk("t0_a3", out_a3, 1);
        offer(1'b1, 5'd2, 3'd0, 4'd1, 96'hB);
        step();
        chk("t1_tnew", out_tnew, 0);
        chk("t1_a3", out_a3, 2);
        offer(1'b0, 5'd3, 3'd7, 4'hF, 96'hC);
        step();
        chk("tF_tnew", out_tnew, 4'hE);
        chk("tF_src", out_src, 7);
        in_valid = 1'b0;
        step();
        chk("drain_valid", out_valid, 0);
        chk("drain_tnew", out_tnew, 0);
        chk("drain_src", out_src, 0);

        // Stall with entry A held; B offered
        out_ready = 1'b0;
        offer(1'b1, 5'd3, 3'd1, 4'd2, 96'hAAAA);
        step();
        chk("stallA_valid", out_valid, 1);
        chk("stallA_a3", out_a3, 3);
        offer(1'b1, 5'd4, 3'd2, 4'd5, 96'hBBBB);
        for (int i = 0; i < 5; i++) begin
            step();
`ifdef PIPE_STAGE_SKID_EN
            in_valid = 1'b0;
`endif
            chk("hold_a3", out_a3, 3);
            chk("hold_data", out_data, 128'hAAAA);
            chk("hold_tnew", out_tnew, 1);
            chk("hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("relB_valid", out_valid, 1);
        chk("relB_a3", out_a3, 4);
        chk("relB_tnew", out_tnew, 4);
        chk("relB_data", out_data, 128'hBBBB);
        step();
        chk("relB_drain", out_valid, 0);

        // Flush kills the held entry and the offered input
        out_ready = 1'b0;
        offer(1'b1, 5'd6, 3'd1, 4'd1, 96'hCCCC);
        step();
        chk("flC_a3", out_a3, 6);
        flush = 1'b1;
        offer(1'b1, 5'd7, 3'd1, 4'd1, 96'hDDDD);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_rw", out_regwrite, 0);
        chk("fl_a3", out_a3, 0);
        chk("fl_data", out_data, 0);
        chk("fl_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        chk("fl_noD", out_valid, 0);

        // Reset mid-stall with input offered
        out_ready = 1'b0;
        offer(1'b1, 5'd9, 3'd3, 4'd4, 96'hEEEE);
        step();
        chk("stE_a3", out_a3, 9);
        offer(1'b1, 5'd10, 3'd3, 4'd4, 96'hFFFF);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        chk("rs_valid", out_valid, 0);
        chk("rs_ready", in_ready, 1);
        chk("rs_a3", out_a3, 0);
        chk("rs_data", out_data, 0);
        chk("rs_rw", out_regwrite, 0);
        chk("rs_src", out_src, 0);
        chk("rs_tnew", out_tnew, 0);
        out_ready = 1'b1;
        step();
        chk("rs_empty", out_valid, 0);

        // Normal traffic resumes after reset
        offer(1'b1, 5'd11, 3'd5, 4'd0, 96'h1);
        step();
        in_valid = 1'b0;
        chk("post_valid", out_valid, 1);
        chk("post_a3", out_a3, 11);
        chk("post_tnew", out_tnew, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 96, meaning width of the packed payload (ExeResult/PCNxt/DMData style words).
REQ-002 SHALL have parameter TNEW_W, default 4, meaning width of the Tnew countdown field.
REQ-003 SHALL have parameter SRC_W, default 3, meaning width of the register-write-data-source select.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous kill of all held entries (interrupt/exception request).
REQ-007 SHALL have ports in_valid input 1 and in_ready output 1, the upstream handshake.
REQ-008 SHALL have ports in_regwrite input 1, in_a3 input 5, in_src input SRC_W, in_tnew input TNEW_W and in_data input DATA_W, the upstream fields.
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1, the downstream handshake.
REQ-010 SHALL have ports out_regwrite output 1, out_a3 output 5, out_src output SRC_W, out_tnew output TNEW_W and out_data output DATA_W, the registered fields.

Function
REQ-011 SHALL transfer an entry upstream only when in_valid and in_ready are both 1 at a rising edge, and downstream only when out_valid and out_ready are both 1.
REQ-012 SHALL store the captured Tnew as in_tnew-1 when in_tnew>0 and as 0 when in_tnew==0, unsigned saturating, with no wrap to all-ones.
REQ-013 SHALL store in_regwrite, in_a3, in_src and in_data unmodified on capture.
REQ-014 SHALL hold every output stable while out_valid==1 and out_ready==0.
REQ-015 SHALL drive out_regwrite=0, out_a3=0, out_src=0, out_tnew=0 and out_data=0 whenever out_valid==0, so hazard logic sees a bubble.
REQ-016 SHALL, on flush==1, invalidate all entries at that edge with out_valid=0 next cycle; flush has priority over simultaneous capture and dequeue, and the input offered in that cycle is dropped.
REQ-017 SHALL deliver entries strictly in capture order, never duplicating or losing an entry except through flush or reset.
REQ-018 SHALL, with one entry held and out_ready==1 and in_valid==1 in the same cycle, dequeue the old entry and capture the new one at the same edge (zero-bubble pass-through).

Reset
REQ-019 SHALL, on reset==1 at a rising edge, clear all entries; next cycle out_valid=0 and all out_* fields 0 per REQ-015, and in_ready=1.
REQ-020 SHALL give reset priority over flush and over any handshake in the same cycle; a reset mid-stall discards the held entry.

Configuration
REQ-021 SHALL, when macro PIPE_STAGE_SKID_EN is defined, implement two entries (main + skid) with in_ready registered and equal to "skid entry empty"; an input accepted while main is stalled goes to skid; skid moves to main when main dequeues; full throughput with no combinational out_ready->in_ready path.
REQ-022 SHALL, when PIPE_STAGE_SKID_EN is undefined, implement a single entry with in_ready = !out_valid || out_ready (combinational), and all other requirements unchanged.

Verification
REQ-023 SHALL cover: reset, then in_valid=1 in_tnew=3 in_a3=5'd8 in_data=0x1234 with out_ready=1 -> next cycle out_valid=1 out_tnew=2 out_a3=8 out_data=0x1234.
REQ-024 SHALL cover: capture in_tnew=0 and in_tnew=1 back-to-back -> out_tnew=0 for both, never 4'hF.
REQ-025 SHALL cover: out_ready=0 for 5 cycles with entry A held -> outputs constant; with SKID_EN a second entry B is accepted, then in_ready=0; on out_ready=1, A then B emerge on consecutive cycles.
REQ-026 SHALL cover: flush=1 with in_valid=1 and entry held -> next cycle out_valid=0, out_regwrite=0, out_a3=0; the flushed input never appears.
REQ-027 SHALL cover: reset=1 and flush=0 during a stall with in_valid=1 -> next cycle out_valid=0, in_ready=1, all outputs 0.
